mcm_pack_multi: RTL
===================

Name: mcm_pack_multi

Overview:
- Parametrised next-generation MCM packer.
- After the coordinator signals that MCM RAM is filled, it waits for a start edge on the group-memory busy line. It then reads bytes from the MCM RAM, packs them into WORD_W orbit words, and writes them to the group distributor on a strided per-stream address map.
- Adds a runtime packing mode (zero-filled LSBs, or LSBs from tail bytes), a selectable start edge, a frame-done pulse and a sticky overrun flag.

Parameters:
- BYTE_W, 8, RAM byte width.
- WORD_W, 12, output word width. Must be BYTE_W+2 or more.
- RD_AW, 8, MCM RAM read address width.
- WR_AW, 10, distributor address width.
- RD_LAT, 3, cycles from oRdEn asserted to iData valid. Range 1..7.
- WORDS_PER_STREAM, 16, words written per stream. Must be a multiple of 4.
- NUM_STREAMS, 4, number of streams per frame. Range 1..16.
- ADDR_STRIDE, 32, address increment between successive words of one stream.
- STREAM_OFFSET, 8, base address offset between streams.
- START_EDGE, 1, start edge on the synchronised iBusy: 1 = rising edge, 0 = falling edge.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- iDone  in  1  coordinator done (MCM RAM filled). Level signal.
- iMode  in  1  packing mode, sampled on the IDLE->WAITMEM transition.
- iData  in  BYTE_W  MCM RAM read data.
- oRdAddr  out  RD_AW  MCM RAM read address.
- oRdEn  out  1  MCM RAM read enable.
- iBusy  in  1  group LCB busy, asynchronous to clk.
- oData  out  WORD_W  orbit word to the distributor.
- oAddr  out  WR_AW  orbit address to the distributor.
- oWren  out  1  write strobe to the distributor.
- oBusy  out  1  high while the packer owns the group memories.
- oFrameDone  out  1  one-cycle pulse when the last word of a frame has been written.
- oErr  out  1  sticky overrun flag.

Behaviour:

Reset:
- All outputs are 0.
- State is IDLE; all counters and the iBusy synchroniser are 0.

Synchroniser:
- iBusy passes through a 3-stage shift register s[2:0].
- Start edge: rising = s[1]&~s[2]; falling = ~s[1]&s[2].

FSM states: IDLE, WAITMEM, RD, CAP, WR, NEXT, DONE.
- IDLE:
  - On iDone=1: latch mode from iMode, set oRdAddr=0, clear oErr, clear stream and word counters, go to WAITMEM.
- WAITMEM:
  - On the start edge: set oBusy=1 and go to RD.
  - iDone falling while in WAITMEM returns to IDLE without writing anything.
- RD:
  - oRdEn=1 for exactly one cycle, then go to CAP.
- CAP:
  - Wait until RD_LAT cycles have elapsed since oRdEn was asserted, then capture iData.
  - After the capture, increment oRdAddr (wraps modulo 2^RD_AW).
  - Mode 0: word = {byte, (WORD_W-BYTE_W) zeros}, go to WR.
  - Mode 1, byte is one of 4 data bytes: store it in buf[j], j=0..3, then go to RD.
  - Mode 1, 5th (tail) byte: word j takes its LSBs from tail[2j+1:2j] and its MSBs from buf[j]. Any remaining middle bits are zero. Go to WR and emit the 4 words in order j=0..3.
- WR:
  - oWren=1 for one cycle, with oData and oAddr valid in that same cycle. oWren is 0 in the following cycle.
  - Consecutive writes of a mode-1 group are spaced 2 cycles apart.
- Address rule:
  - oAddr = s*STREAM_OFFSET + k*ADDR_STRIDE, truncated modulo 2^WR_AW.
  - s is the stream index (0..NUM_STREAMS-1); k is the word index (0..WORDS_PER_STREAM-1).
  - Computed incrementally; no multiplier.
- NEXT:
  - If k < WORDS_PER_STREAM-1: k+1, return to RD.
  - Otherwise k=0, s+1. If s was NUM_STREAMS-1: oBusy=0, oFrameDone=1 for one cycle, go to DONE.
- DONE:
  - Go to IDLE once iDone=0.
  - iDone held high therefore never retriggers a frame.

Per-frame totals:
- Bytes read: WORDS_PER_STREAM*NUM_STREAMS in mode 0, ×5/4 in mode 1.
- Words written: always WORDS_PER_STREAM*NUM_STREAMS.

Overrun:
- Any start edge seen while oBusy=1 sets oErr.
- The frame still completes normally.
- oErr is cleared only on the next IDLE->WAITMEM transition.
- iDone falling during RD..NEXT is ignored; the frame completes.
- iMode changes mid-frame are ignored.

Reset mid-frame:
- Immediate return to reset values.
- oWren, oRdEn and oBusy drop asynchronously.

Test Plan:
- Mode 0, defaults; RAM[a]=a; iDone=1; rising edge on iBusy -> 64 writes, first 3 oAddr=0,32,64 with oData=0x000,0x010,0x020. Stream 1 starts at oAddr=8. Last write oAddr=(3*8+15*32) mod 1024=504, oData=0x3F0. oFrameDone pulses once; oBusy falls in the same cycle.
- Mode 1; RAM bytes 0xAB,0xCD,0xEF,0x12,tail 0xE4 -> 4 writes 0xAB0,0xCD1,0xEF2,0x123; 80 reads total; oRdAddr=80 at end.
- iBusy rising edge applied while oBusy=1 mid-frame -> oErr=1 from the edge onward, all 64 words still written; next iDone rising clears oErr.
- iDone held high after DONE, further iBusy edges -> no oRdEn, no oWren; drop iDone then raise it again with a new edge -> new frame restarts from oRdAddr=0.
- RD_LAT=1, START_EDGE=0; falling iBusy edge -> capture one cycle after oRdEn; no writes before the falling edge.
- Assert reset during the 10th write -> all outputs 0 immediately; after release with iDone low, the block stays idle.

Source files
------------

// File: rtl/mcm_pack_multi.sv
// MCM packer: reads bytes from MCM RAM after the coordinator is done and a start
// edge appears on the group-memory busy line, packs them into orbit words and
// writes them to the group distributor on a strided per-stream address map.
module mcm_pack_multi #(
    parameter int BYTE_W           = 8,
    parameter int WORD_W           = 12,
    parameter int RD_AW            = 8,
    parameter int WR_AW            = 10,
    parameter int RD_LAT           = 3,
    parameter int WORDS_PER_STREAM = 16,
    parameter int NUM_STREAMS      = 4,
    parameter int ADDR_STRIDE      = 32,
    parameter int STREAM_OFFSET    = 8,
    parameter int START_EDGE       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iDone,
    input  logic              iMode,
    input  logic [BYTE_W-1:0] iData,
    output logic [RD_AW-1:0]  oRdAddr,
    output logic              oRdEn,
    input  logic              iBusy,
    output logic [WORD_W-1:0] oData,
    output logic [WR_AW-1:0]  oAddr,
    output logic              oWren,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic              oErr
);

    localparam int KW = (WORDS_PER_STREAM > 1) ? $clog2(WORDS_PER_STREAM) : 1;
    localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    localparam logic [KW-1:0]    K_LAST  = KW'(WORDS_PER_STREAM - 1);
    localparam logic [KW-1:0]    K_ONE   = KW'(1);
    localparam logic [SW-1:0]    S_LAST  = SW'(NUM_STREAMS - 1);
    localparam logic [SW-1:0]    S_ONE   = SW'(1);
    localparam logic [2:0]       LAT     = 3'(RD_LAT);
    localparam logic [RD_AW-1:0] RD_ONE  = RD_AW'(1);
    localparam logic [WR_AW-1:0] STRIDE  = WR_AW'(ADDR_STRIDE);
    localparam logic [WR_AW-1:0] OFFSET  = WR_AW'(STREAM_OFFSET);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITMEM = 3'd1,
        RD      = 3'd2,
        CAP     = 3'd3,
        WR      = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
    } stateT;

    stateT              stateR, stateN;
    logic [2:0]         syncR;
    logic               startEdge;
    logic               modeR, modeN;
    logic [RD_AW-1:0]   rdAddrR, rdAddrN;
    logic               rdEnR, rdEnN;
    logic [2:0]         latCntR, latCntN;
    logic [2:0]         byteCntR, byteCntN;
    logic [1:0]         grpIdxR, grpIdxN;
    logic [BYTE_W-1:0]  bufR [4];
    logic [BYTE_W-1:0]  bufN [4];
    logic [WORD_W-1:0]  wordBufR [4];
    logic [WORD_W-1:0]  wordBufN [4];
    logic [KW-1:0]      kR, kN;
    logic [SW-1:0]      sR, sN;
    logic [WR_AW-1:0]   baseR, baseN;
    logic [WR_AW-1:0]   addrR, addrN;
    logic [WORD_W-1:0]  dataR, dataN;
    logic               wrenR, wrenN;
    logic               busyR, busyN;
    logic               frameDoneR, frameDoneN;
    logic               errR, errN;

    // Byte in the MSBs, zero-filled LSBs.
    function automatic logic [WORD_W-1:0] packZero(input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] w;
        w = '0;
        w[WORD_W-1 -: BYTE_W] = b;
        return w;
    endfunction

    // Byte in the MSBs, two tail bits in the LSBs, middle bits zero.
    function automatic logic [WORD_W-1:0] packTail(input logic [BYTE_W-1:0] b,
                                                   input logic [1:0] t);
        logic [WORD_W-1:0] w;
        w = '0;
        w[WORD_W-1 -: BYTE_W] = b;
        w[1:0] = t;
        return w;
    endfunction

    // Three-stage synchroniser for the asynchronous busy line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncR <= 3'b000;
        end else begin
            syncR <= {syncR[1:0], iBusy};
        end
    end

    // Start-edge detection on the synchronised busy line.
    always_comb begin
        startEdge = 1'b0;
        if (START_EDGE != 0) begin
            startEdge = syncR[1] & ~syncR[2];
        end else begin
            startEdge = ~syncR[1] & syncR[2];
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        stateN     = stateR;
        modeN      = modeR;
        rdAddrN    = rdAddrR;
        latCntN    = latCntR;
        byteCntN   = byteCntR;
        grpIdxN    = grpIdxR;
        bufN       = bufR;
        wordBufN   = wordBufR;
        kN         = kR;
        sN         = sR;
        baseN      = baseR;
        addrN      = addrR;
        dataN      = dataR;
        busyN      = busyR;
        frameDoneN = 1'b0;
        errN       = errR | (startEdge & busyR);

        case (stateR)
            IDLE: begin
                if (iDone) begin
                    modeN    = iMode;
                    rdAddrN  = '0;
                    errN     = 1'b0;
                    kN       = '0;
                    sN       = '0;
                    baseN    = '0;
                    addrN    = '0;
                    byteCntN = 3'd0;
                    grpIdxN  = 2'd0;
                    stateN   = WAITMEM;
                end else begin
                    stateN = IDLE;
                end
            end
            WAITMEM: begin
                if (!iDone) begin
                    stateN = IDLE;
                end else if (startEdge) begin
                    busyN  = 1'b1;
                    stateN = RD;
                end else begin
                    stateN = WAITMEM;
                end
            end
            RD: begin
                latCntN = 3'd1;
                stateN  = CAP;
            end
            CAP: begin
                if (latCntR == LAT) begin
                    rdAddrN = rdAddrR + RD_ONE;
                    if (!modeR) begin
                        dataN  = packZero(iData);
                        stateN = WR;
                    end else if (byteCntR != 3'd4) begin
                        bufN[byteCntR[1:0]] = iData;
                        byteCntN = byteCntR + 3'd1;
                        stateN   = RD;
                    end else begin
                        // Tail byte: bits [2j+1:2j] belong to word j of the group.
                        for (int j = 0; j < 4; j++) begin
                            wordBufN[j] = packTail(bufR[j], iData[2*j +: 2]);
                        end
                        dataN    = packTail(bufR[0], iData[1:0]);
                        byteCntN = 3'd0;
                        grpIdxN  = 2'd0;
                        stateN   = WR;
                    end
                end else begin
                    latCntN = latCntR + 3'd1;
                    stateN  = CAP;
                end
            end
            WR: begin
                stateN = NEXT;
            end
            NEXT: begin
                if (kR != K_LAST) begin
                    kN    = kR + K_ONE;
                    addrN = addrR + STRIDE;
                end else begin
                    kN    = '0;
                    sN    = sR + S_ONE;
                    baseN = baseR + OFFSET;
                    addrN = baseR + OFFSET;
                end
                if ((kR == K_LAST) && (sR == S_LAST)) begin
                    busyN      = 1'b0;
                    frameDoneN = 1'b1;
                    stateN     = DONE;
                end else if (modeR && (grpIdxR != 2'd3)) begin
                    grpIdxN = grpIdxR + 2'd1;
                    dataN   = wordBufR[grpIdxR + 2'd1];
                    stateN  = WR;
                end else begin
                    stateN = RD;
                end
            end
            DONE: begin
                if (!iDone) begin
                    stateN = IDLE;
                end else begin
                    stateN = DONE;
                end
            end
            default: begin
                stateN = IDLE;
            end
        endcase

        rdEnN = (stateN == RD);
        wrenN = (stateN == WR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateR     <= IDLE;
            modeR      <= 1'b0;
            rdAddrR    <= '0;
            rdEnR      <= 1'b0;
            latCntR    <= 3'd0;
            byteCntR   <= 3'd0;
            grpIdxR    <= 2'd0;
            kR         <= '0;
            sR         <= '0;
            baseR      <= '0;
            addrR      <= '0;
            dataR      <= '0;
            wrenR      <= 1'b0;
            busyR      <= 1'b0;
            frameDoneR <= 1'b0;
            errR       <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                bufR[j]     <= '0;
                wordBufR[j] <= '0;
            end
        end else begin
            stateR     <= stateN;
            modeR      <= modeN;
            rdAddrR    <= rdAddrN;
            rdEnR      <= rdEnN;
            latCntR    <= latCntN;
            byteCntR   <= byteCntN;
            grpIdxR    <= grpIdxN;
            kR         <= kN;
            sR         <= sN;
            baseR      <= baseN;
            addrR      <= addrN;
            dataR      <= dataN;
            wrenR      <= wrenN;
            busyR      <= busyN;
            frameDoneR <= frameDoneN;
            errR       <= errN;
            for (int j = 0; j < 4; j++) begin
                bufR[j]     <= bufN[j];
                wordBufR[j] <= wordBufN[j];
            end
        end
    end

    assign oRdAddr    = rdAddrR;
    assign oRdEn      = rdEnR;
    assign oData      = dataR;
    assign oAddr      = addrR;
    assign oWren      = wrenR;
    assign oBusy      = busyR;
    assign oFrameDone = frameDoneR;
    assign oErr       = errR;

endmodule
